// File: rtl/ram_stream_fifo.sv
// ram_stream_fifo: RAM-backed stream FIFO with a prefetching output register and skid slot.
module ram_stream_fifo #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [WIDTH_P-1:0]             data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [WIDTH_P-1:0]             data_o,
  output logic [$clog2(DEPTH_P+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH_P);
  localparam int CW = $clog2(DEPTH_P+1);
  logic [WIDTH_P-1:0] mem [DEPTH_P];
  logic [WIDTH_P-1:0] ram_q, skid_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pend, skid_v, push, pop, free, rd_en;
  logic [CW-1:0] occ, ram_cnt, count_n;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH_P-1) ? '0 : p + 1'b1;
  endfunction
  // Read ahead whenever the landing slots (output + skid) can take the beat next edge.
  always_comb begin
    push = valid_i & ready_o;
    pop = valid_o & ready_i;
    free = !valid_o || ready_i;
    occ = CW'(valid_o) + CW'(skid_v) + CW'(pend);
    ram_cnt = count_o - occ;
    rd_en = (ram_cnt != '0) && (occ - CW'(pop) < CW'(2));
    count_n = count_o + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
    if (rd_en) ram_q <= mem[rd_ptr];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_o <= '0;
      ready_o <= 1'b0;
      valid_o <= 1'b0;
      data_o <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
      pend <= 1'b0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      pend <= rd_en;
      count_o <= count_n;
      ready_o <= count_n < CW'(DEPTH_P);
      valid_o <= free ? (skid_v || pend) : 1'b1;
      if (free && (skid_v || pend)) data_o <= skid_v ? skid_d : ram_q;
      skid_v <= free ? (skid_v && pend) : (skid_v || pend);
      if (pend && (skid_v || !free)) skid_d <= ram_q;
    end
  end
endmodule

// File: tb/tb_ram_stream_fifo.sv
// tb_ram_stream_fifo: queue-model checker plus directed and random stream scenarios.
module tb_ram_stream_fifo;
  localparam int W = 8;
  localparam int D = 16;
  localparam int CW = $clog2(D+1);
  logic clk_i = 0, rst_i = 1, valid_i = 0, ready_i = 0;
  logic [W-1:0] data_i = '0, data_o;
  logic ready_o, valid_o;
  logic [CW-1:0] count_o;
  int checks = 0, errors = 0;
  logic [W-1:0] mq[$];
  int mt[$];
  int ec = 0, npush = 0;
  bit m_rdy = 0;
  logic [W-1:0] got[$];

  ram_stream_fifo #(.WIDTH_P(W), .DEPTH_P(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  // A beat becomes visible at the output two edges after it was accepted.
  function automatic bit m_vis();
    return mq.size() > 0 && ec >= mt[0] + 2;
  endfunction

  initial forever begin
    bit p, q;
    @(posedge clk_i);
    p = m_vis() && ready_i;
    q = valid_i && m_rdy;
    ec++;
    if (rst_i) begin
      mq.delete();
      mt.delete();
      m_rdy = 0;
    end else begin
      if (p) begin
        void'(mq.pop_front());
        void'(mt.pop_front());
      end
      if (q) begin
        mq.push_back(data_i);
        mt.push_back(ec);
        npush++;
      end
      m_rdy = mq.size() < D;
    end
    #1;
    chk("valid", valid_o, m_vis());
    chk("count", count_o, mq.size());
    chk("ready", ready_o, m_rdy);
    if (m_vis()) chk("data", data_o, mq[0]);
  end

  task automatic drain();
    int n = 0;
    valid_i = 0;
    ready_i = 1;
    got.delete();
    while (count_o != 0 && n < 200) begin
      if (valid_o) got.push_back(data_o);
      @(negedge clk_i);
      n++;
    end
    chk("drain_done", count_o, 0);
  endtask

  initial begin
    int base, n;
    bit pv, pr;
    logic [W-1:0] pd;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    chk("release_ready", ready_o, 1);
    ready_i = 1;
    valid_i = 1; data_i = 8'h01; @(negedge clk_i);
    chk("t1_lat0", valid_o, 0);
    data_i = 8'h02; @(negedge clk_i);
    chk("t1_lat1", valid_o, 0);
    data_i = 8'h03; @(negedge clk_i);
    chk("t1_first_v", valid_o, 1);
    chk("t1_first_d", data_o, 8'h01);
    valid_i = 0; @(negedge clk_i);
    chk("t1_second", data_o, 8'h02);
    @(negedge clk_i);
    chk("t1_third", data_o, 8'h03);
    drain();
    ready_i = 0;
    for (int i = 0; i < 16; i++) begin
      valid_i = 1; data_i = W'(8'h10 + i); @(negedge clk_i);
    end
    chk("t2_full_cnt", count_o, 16);
    chk("t2_full_rdy", ready_o, 0);
    data_i = 8'h99; @(negedge clk_i);
    chk("t2_reject", count_o, 16);
    ready_i = 1; data_i = 8'h20; @(negedge clk_i);
    chk("t3_rdy_up", ready_o, 1);
    chk("t3_cnt15", count_o, 15);
    ready_i = 0; @(negedge clk_i);
    chk("t3_refill", count_o, 16);
    drain();
    chk("t3_n", got.size(), 16);
    if (got.size() == 16) begin
      chk("t3_head", got[0], 8'h11);
      chk("t3_tail", got[15], 8'h20);
    end
    base = npush; n = 0; pv = 0; pr = 0; pd = '0;
    while (npush - base < 100 && n < 3000) begin
      if (pv && !pr) begin
        chk("t4_stall_v", valid_o, 1);
        chk("t4_stall_d", data_o, pd);
      end
      valid_i = $urandom_range(0, 3) != 0;
      ready_i = $urandom_range(0, 2) != 0;
      data_i = W'(npush - base);
      pv = valid_o; pr = ready_i; pd = data_o;
      @(negedge clk_i);
      n++;
    end
    chk("t4_pushed", npush - base, 100);
    drain();
    ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1; data_i = W'(8'h50 + i); @(negedge clk_i);
    end
    ready_i = 1;
    for (int i = 0; i < 20; i++) begin
      data_i = W'(8'h60 + i); @(negedge clk_i);
      chk("t5_cnt", count_o, 5);
      chk("t5_rdy", ready_o, 1);
    end
    ready_i = 0;
    repeat (2) @(negedge clk_i);
    chk("t6_cnt7", count_o, 7);
    rst_i = 1; data_i = 8'h77; @(negedge clk_i);
    chk("t6_rst_v", valid_o, 0);
    chk("t6_rst_c", count_o, 0);
    chk("t6_rst_d", data_o, 0);
    chk("t6_rst_r", ready_o, 0);
    rst_i = 0; data_i = 8'hAA; @(negedge clk_i);
    chk("t6_rel_r", ready_o, 1);
    @(negedge clk_i);
    valid_i = 0; ready_i = 1; @(negedge clk_i);
    @(negedge clk_i);
    chk("t6_aa_v", valid_o, 1);
    chk("t6_aa_d", data_o, 8'hAA);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
